// File: rtl/serial_add_arb.sv
// rtl/serial_add_arb.sv - bit-serial adder shared by two requesters under round-robin arbitration (optional ovf output: SERIAL_ADD_OVF_EN)
module serial_add_arb #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             cin0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic             cin1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic             owner_q;
    logic             last_q;   // requester served most recently
    logic             bit_s, bit_c;

    // One full-adder cell applied to the current LSBs
    always_comb begin
        bit_s = a_sh[0] ^ b_sh[0] ^ carry_q;
        bit_c = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry_q) | (b_sh[0] & carry_q);
    end

    // Next-state and grant decode; grants only from IDLE, never during reset
    always_comb begin
        state_d = state_q;
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        case (state_q)
            IDLE: begin
                if (rst_n) begin
                    if (req0 && (!req1 || last_q)) begin
                        gnt0 = 1'b1;
                    end else if (req1) begin
                        gnt1 = 1'b1;
                    end
                    if (req0 || req1) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (cnt_q == LAST_BIT) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Status outputs derived from state and grant
    always_comb begin
        done = (state_q == DONE);
        busy = (state_q != IDLE) || gnt0 || gnt1;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand capture, serial add, and result publication on the last bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh    <= '0;
            b_sh    <= '0;
            sum_sh  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            sum     <= '0;
            cout    <= 1'b0;
            done_id <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf     <= 1'b0;
`endif
        end else if (gnt0) begin
            a_sh    <= a0;
            b_sh    <= b0;
            carry_q <= cin0;
            cnt_q   <= '0;
            owner_q <= 1'b0;
            last_q  <= 1'b0;
        end else if (gnt1) begin
            a_sh    <= a1;
            b_sh    <= b1;
            carry_q <= cin1;
            cnt_q   <= '0;
            owner_q <= 1'b1;
            last_q  <= 1'b1;
        end else if (state_q == RUN) begin
            a_sh    <= a_sh >> 1;
            b_sh    <= b_sh >> 1;
            sum_sh  <= {bit_s, sum_sh[WIDTH-1:1]};
            carry_q <= bit_c;
            cnt_q   <= cnt_q + 1'b1;
            if (cnt_q == LAST_BIT) begin
                // Results appear together with done and stay until the next done
                sum     <= {bit_s, sum_sh[WIDTH-1:1]};
                cout    <= bit_c;
                done_id <= owner_q;
`ifdef SERIAL_ADD_OVF_EN
                // carry_q here is still the carry into the MSB
                ovf     <= carry_q ^ bit_c;
`endif
            end
        end
    end

endmodule

// File: tb/tb_serial_add_arb.sv
// tb/tb_serial_add_arb.sv - self-checking bench for serial_add_arb with a behavioural arithmetic/arbitration model
module tb_serial_add_arb;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0 = 1'b0, req1 = 1'b0;
    logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic         cin0 = 1'b0, cin1 = 1'b0;
    logic         gnt0, gnt1, busy, done, done_id, cout;
    logic [W-1:0] sum;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state
    int           m_last = 1;
    logic [W-1:0] exp_sum = '0;
    logic         exp_cout = 1'b0;
    logic         exp_id = 1'b0;
    logic         exp_ovf = 1'b0;

    serial_add_arb #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .a0(a0), .b0(b0), .cin0(cin0),
        .req1(req1), .a1(a1), .b1(b1), .cin1(cin1),
        .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done),
        .done_id(done_id), .sum(sum), .cout(cout)
`ifdef SERIAL_ADD_OVF_EN
        , .ovf(ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_held(input string tag);
        chk({tag, "_sum"}, 32'(sum), 32'(exp_sum));
        chk({tag, "_cout"}, 32'(cout), 32'(exp_cout));
        chk({tag, "_id"}, 32'(done_id), 32'(exp_id));
`ifdef SERIAL_ADD_OVF_EN
        chk({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
`endif
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_gnt0"}, 32'(gnt0), 32'd0);
        chk({tag, "_gnt1"}, 32'(gnt1), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        exp_sum = '0; exp_cout = 1'b0; exp_id = 1'b0; exp_ovf = 1'b0;
        check_held(tag);
    endtask

    // Called at a negedge with the DUT idle; runs one full transaction.
    task automatic serve(input bit r0, input bit r1, input bit raise_other);
        int           w;
        logic [W:0]   full;
        logic         sa, sb;
        req0 = r0;
        req1 = r1;
        #1;
        w = (r0 && (!r1 || m_last == 1)) ? 0 : 1;
        chk("gnt0", 32'(gnt0), 32'(w == 0));
        chk("gnt1", 32'(gnt1), 32'(w == 1));
        chk("busy_at_gnt", 32'(busy), 32'd1);
        chk("done_at_gnt", 32'(done), 32'd0);
        check_held("held_at_gnt");
        if (w == 0) begin
            full = {1'b0, a0} + {1'b0, b0} + (W+1)'(cin0);
            sa = a0[W-1]; sb = b0[W-1];
        end else begin
            full = {1'b0, a1} + {1'b0, b1} + (W+1)'(cin1);
            sa = a1[W-1]; sb = b1[W-1];
        end
        m_last = w;
        @(negedge clk);
        // Winner releases its request and changes operands; the DUT must ignore them
        if (w == 0) begin
            req0 = 1'b0; a0 = W'($urandom); b0 = W'($urandom); cin0 = ~cin0;
        end else begin
            req1 = 1'b0; a1 = W'($urandom); b1 = W'($urandom); cin1 = ~cin1;
        end
        for (int i = 1; i <= W; i++) begin
            if (raise_other && i == 3) begin
                if (w == 0) req1 = 1'b1; else req0 = 1'b1;
            end
            #1;
            chk("run_gnt0", 32'(gnt0), 32'd0);
            chk("run_gnt1", 32'(gnt1), 32'd0);
            chk("run_done", 32'(done), 32'd0);
            chk("run_busy", 32'(busy), 32'd1);
            check_held("run_held");
            @(negedge clk);
        end
        #1;
        exp_sum  = full[W-1:0];
        exp_cout = full[W];
        exp_id   = (w == 1);
        exp_ovf  = (sa == sb) && (full[W-1] != sa);
        chk("done", 32'(done), 32'd1);
        chk("done_busy", 32'(busy), 32'd1);
        chk("done_gnt0", 32'(gnt0), 32'd0);
        chk("done_gnt1", 32'(gnt1), 32'd0);
        check_held("result");
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req0 = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_all_zero("reset");
        req0 = 1'b0;
        req1 = 1'b0;
        rst_n = 1'b1;
        m_last = 1;
        @(negedge clk);
        #1;
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
    endtask

    initial begin
        @(negedge clk);
        do_reset();

        // Test 1
        a0 = 8'h5A; b0 = 8'h33; cin0 = 1'b0;
        serve(1'b1, 1'b0, 1'b0);
        chk("t1_sum", 32'(sum), 32'h8D);
        chk("t1_cout", 32'(cout), 32'd0);
        chk("t1_id", 32'(done_id), 32'd0);

        // Test 2
        a1 = 8'hFF; b1 = 8'h01; cin1 = 1'b1;
        serve(1'b0, 1'b1, 1'b0);
        chk("t2_sum", 32'(sum), 32'h01);
        chk("t2_cout", 32'(cout), 32'd1);
        chk("t2_id", 32'(done_id), 32'd1);

        // Test 3: both held after reset
        do_reset();
        a0 = W'($urandom); b0 = W'($urandom); a1 = W'($urandom); b1 = W'($urandom);
        serve(1'b1, 1'b1, 1'b0);
        chk("t3_first_id", 32'(done_id), 32'd0);
        serve(1'b0, 1'b1, 1'b0);
        chk("t3_second_id", 32'(done_id), 32'd1);
        serve(1'b1, 1'b1, 1'b0);
        chk("t3_third_id", 32'(done_id), 32'd0);
        req1 = 1'b0;

        // Test 4: reset in the middle of RUN abandons the add
        a0 = 8'h11; b0 = 8'h22; cin0 = 1'b0;
        req0 = 1'b1;
        #1;
        chk("t4_gnt0", 32'(gnt0), 32'd1);
        @(negedge clk);
        req0 = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("t4_rst_done", 32'(done), 32'd0);
            if (i == 3) begin
                check_all_zero("t4_rst");
                rst_n = 1'b1;
                m_last = 1;
            end
            @(negedge clk);
        end
        check_all_zero("t4_after");
        a0 = 8'd3; b0 = 8'd4; cin0 = 1'b0;
        serve(1'b1, 1'b0, 1'b0);
        chk("t4_sum", 32'(sum), 32'h07);

        // Test 5: operand changes after grant ignored; req1 raised while busy waits
        a0 = W'($urandom); b0 = W'($urandom); cin0 = 1'(($urandom));
        serve(1'b1, 1'b0, 1'b1);
        serve(1'b0, 1'b1, 1'b0);
        chk("t5_id", 32'(done_id), 32'd1);

`ifdef SERIAL_ADD_OVF_EN
        // Test 6: signed overflow
        a0 = 8'h7F; b0 = 8'h01; cin0 = 1'b0;
        serve(1'b1, 1'b0, 1'b0);
        chk("t6a_sum", 32'(sum), 32'h80);
        chk("t6a_ovf", 32'(ovf), 32'd1);
        a0 = 8'h80; b0 = 8'h80; cin0 = 1'b0;
        serve(1'b1, 1'b0, 1'b0);
        chk("t6b_sum", 32'(sum), 32'h00);
        chk("t6b_cout", 32'(cout), 32'd1);
        chk("t6b_ovf", 32'(ovf), 32'd1);
        a0 = 8'h10; b0 = 8'h20; cin0 = 1'b0;
        serve(1'b1, 1'b0, 1'b0);
        chk("t6c_ovf", 32'(ovf), 32'd0);
`endif

        // Randomized traffic against the model
        for (int n = 0; n < 24; n++) begin
            int r;
            r = $urandom_range(1, 3);
            a0 = W'($urandom); b0 = W'($urandom); cin0 = 1'($urandom);
            a1 = W'($urandom); b1 = W'($urandom); cin1 = 1'($urandom);
            serve(r[0], r[1], 1'($urandom));
        end
        req0 = 1'b0;
        req1 = 1'b0;
        @(negedge clk);
        #1;
        chk("final_busy", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
